// File: rtl/microdisc_drive_mux_if.sv
// Bundle of FDC-side and host-side SD block signals for microdisc_drive_mux.
// slave is the mux's view; master is the view of whatever drives the FDC and host sides.
interface microdisc_drive_mux_if #(
    parameter int unsigned NDRIVES = 4,
    parameter int unsigned DW      = 2
);
    logic [DW-1:0]         dsel;
    logic [31:0]           fdc_sd_lba;
    logic                  fdc_sd_rd;
    logic                  fdc_sd_wr;
    logic [7:0]            fdc_sd_din;
    logic                  fdc_sd_ack;
    logic [8:0]            fdc_sd_buff_addr;
    logic [7:0]            fdc_sd_dout;
    logic                  fdc_sd_dout_strobe;
    logic                  fdc_img_mounted;
    logic                  fdc_img_wp;
    logic [31:0]           fdc_img_size;
    logic                  fdc_ready;
    logic [NDRIVES-1:0]    hps_img_mounted;
    logic                  hps_img_wp;
    logic [31:0]           hps_img_size;
    logic [32*NDRIVES-1:0] hps_sd_lba;
    logic [NDRIVES-1:0]    hps_sd_rd;
    logic [NDRIVES-1:0]    hps_sd_wr;
    logic [NDRIVES-1:0]    hps_sd_ack;
    logic [8:0]            hps_sd_buff_addr;
    logic [7:0]            hps_sd_buff_dout;
    logic                  hps_sd_buff_wr;
    logic [8*NDRIVES-1:0]  hps_sd_din;

    modport slave (
        input  dsel, fdc_sd_lba, fdc_sd_rd, fdc_sd_wr, fdc_sd_din,
        input  hps_img_mounted, hps_img_wp, hps_img_size,
        input  hps_sd_ack, hps_sd_buff_addr, hps_sd_buff_dout, hps_sd_buff_wr,
        output fdc_sd_ack, fdc_sd_buff_addr, fdc_sd_dout, fdc_sd_dout_strobe,
        output fdc_img_mounted, fdc_img_wp, fdc_img_size, fdc_ready,
        output hps_sd_lba, hps_sd_rd, hps_sd_wr, hps_sd_din
    );

    modport master (
        output dsel, fdc_sd_lba, fdc_sd_rd, fdc_sd_wr, fdc_sd_din,
        output hps_img_mounted, hps_img_wp, hps_img_size,
        output hps_sd_ack, hps_sd_buff_addr, hps_sd_buff_dout, hps_sd_buff_wr,
        input  fdc_sd_ack, fdc_sd_buff_addr, fdc_sd_dout, fdc_sd_dout_strobe,
        input  fdc_img_mounted, fdc_img_wp, fdc_img_size, fdc_ready,
        input  hps_sd_lba, hps_sd_rd, hps_sd_wr, hps_sd_din
    );
endinterface

// File: rtl/microdisc_drive_mux.sv
// Routes the Microdisc FDC's single SD block channel to one of NDRIVES host image slots,
// keeping per-drive mount state and re-announcing the image when the active drive changes.
module microdisc_drive_mux #(
    parameter int unsigned NDRIVES = 4,
    parameter int unsigned DW      = 2
) (
    input logic                  CLK_SYS,
    input logic                  nRESET,
    microdisc_drive_mux_if.slave bus
);
    localparam logic [DW-1:0] ActMask = DW'(NDRIVES - 1);

    typedef enum logic [2:0] {StIdle, StReq, StXfer, StFake, StAnnounce} state_e;

    state_e               state_q;
    logic [DW-1:0]        act_q;
    logic [DW-1:0]        xdrv_q;
    logic                 pend_q;
    logic                 fake_cnt_q;
    logic                 fake_ack_q;
    logic                 announce_q;
    logic [NDRIVES-1:0]   rd_q;
    logic [NDRIVES-1:0]   wr_q;
    logic [31:0]          lba_q [NDRIVES];
    logic [NDRIVES-1:0]   mnt_prev_q;
    logic [NDRIVES-1:0]   mounted_q;
    logic [NDRIVES-1:0]   wp_q;
    logic [31:0]          size_q [NDRIVES];

    logic [NDRIVES-1:0]   mnt_rise;
    logic [DW-1:0]        act_sel;
    logic                 busy;
    logic                 act_chg;
    logic                 mnt_hit;
    logic                 req;
    logic                 xack;

    always_comb begin
        mnt_rise = bus.hps_img_mounted & ~mnt_prev_q;
        act_sel  = bus.dsel & ActMask;
        busy     = (state_q == StReq) || (state_q == StXfer);
        act_chg  = (state_q == StIdle) && (act_sel != act_q);
        // act is frozen while busy, so an xdrv hit only matters in flight
        mnt_hit  = mnt_rise[act_q] || (busy && mnt_rise[xdrv_q]);
        req      = bus.fdc_sd_rd || bus.fdc_sd_wr;
        xack     = bus.hps_sd_ack[xdrv_q];
    end

    always_ff @(posedge CLK_SYS or negedge nRESET) begin
        if (!nRESET) begin
            mnt_prev_q <= '0;
            mounted_q  <= '0;
            wp_q       <= '0;
            for (int i = 0; i < NDRIVES; i++) size_q[i] <= '0;
        end else begin
            mnt_prev_q <= bus.hps_img_mounted;
            for (int i = 0; i < NDRIVES; i++) begin
                if (mnt_rise[i]) begin
                    size_q[i]    <= bus.hps_img_size;
                    wp_q[i]      <= bus.hps_img_wp;
                    mounted_q[i] <= |bus.hps_img_size;
                end
            end
        end
    end

    always_ff @(posedge CLK_SYS or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= StIdle;
            act_q      <= '0;
            xdrv_q     <= '0;
            pend_q     <= 1'b0;
            fake_cnt_q <= 1'b0;
            fake_ack_q <= 1'b0;
            announce_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            for (int i = 0; i < NDRIVES; i++) lba_q[i] <= '0;
        end else begin
            if (act_chg) act_q <= act_sel;
            if (act_chg || mnt_hit) begin
                pend_q <= 1'b1;
            end else if (state_q == StIdle && pend_q) begin
                pend_q <= 1'b0;
            end
            announce_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pend_q) begin
                        state_q    <= StAnnounce;
                        announce_q <= 1'b1;
                    end else if (req) begin
                        if (mounted_q[act_q]) begin
                            state_q       <= StReq;
                            xdrv_q        <= act_q;
                            lba_q[act_q]  <= bus.fdc_sd_lba;
                            rd_q[act_q]   <= bus.fdc_sd_rd;
                            wr_q[act_q]   <= !bus.fdc_sd_rd;
                        end else begin
                            state_q    <= StFake;
                            fake_ack_q <= 1'b1;
                            fake_cnt_q <= 1'b0;
                        end
                    end
                end
                StReq: begin
                    if (xack) begin
                        state_q <= StXfer;
                        rd_q    <= '0;
                        wr_q    <= '0;
                    end
                end
                StXfer: begin
                    if (!xack) state_q <= StIdle;
                end
                StFake: begin
                    if (fake_cnt_q) begin
                        state_q    <= StIdle;
                        fake_ack_q <= 1'b0;
                    end else begin
                        fake_cnt_q <= 1'b1;
                    end
                end
                StAnnounce: state_q <= StIdle;
                default:    state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.fdc_sd_ack         = fake_ack_q;
        bus.fdc_sd_buff_addr   = '0;
        bus.fdc_sd_dout        = '0;
        bus.fdc_sd_dout_strobe = 1'b0;
        bus.hps_sd_din         = '0;
        bus.hps_sd_lba         = '0;
        if (state_q == StXfer) begin
            bus.fdc_sd_ack         = xack;
            bus.fdc_sd_buff_addr   = bus.hps_sd_buff_addr;
            bus.fdc_sd_dout        = bus.hps_sd_buff_dout;
            bus.fdc_sd_dout_strobe = bus.hps_sd_buff_wr & xack;
        end
        for (int i = 0; i < NDRIVES; i++) begin
            bus.hps_sd_lba[32*i +: 32] = lba_q[i];
            if (state_q == StXfer && DW'(i) == xdrv_q) bus.hps_sd_din[8*i +: 8] = bus.fdc_sd_din;
        end
        bus.hps_sd_rd       = rd_q;
        bus.hps_sd_wr       = wr_q;
        bus.fdc_img_mounted = announce_q;
        bus.fdc_img_wp      = wp_q[act_q];
        bus.fdc_img_size    = size_q[act_q];
        bus.fdc_ready       = mounted_q[act_q];
    end
endmodule

// File: doc/microdisc_drive_mux.md
# microdisc_drive_mux

Routes the Microdisc WD1793's single SD-block request channel to one of NDRIVES host image slots, selected by the controller's DSEL bits. It sits directly downstream of the Microdisc controller and upstream of the host SD interface. It holds per-drive mount state (mounted, write-protect, size) and presents the selected drive's status back to the FDC. It locks the drive selection for the whole duration of a block transfer, and it re-announces the image to the FDC whenever the active drive changes.

## Interface
Parameters:
- NDRIVES, 4, number of image slots; must be 2 or 4
- DW, 2, width of dsel; log2(NDRIVES) rounded up to at least 1

Ports:
- CLK_SYS  in  1  system clock (24 MHz)
- nRESET  in  1  asynchronous, active-low reset
- dsel  in  DW  drive select from the control register
- fdc_sd_lba  in  32  block address from the FDC
- fdc_sd_rd  in  1  FDC block read request
- fdc_sd_wr  in  1  FDC block write request
- fdc_sd_din  in  8  FDC write data byte
- fdc_sd_ack  out  1  acknowledge returned to the FDC
- fdc_sd_buff_addr  out  9  buffer byte address to the FDC
- fdc_sd_dout  out  8  read data byte to the FDC
- fdc_sd_dout_strobe  out  1  read data strobe to the FDC
- fdc_img_mounted  out  1  one-cycle mount announce to the FDC
- fdc_img_wp  out  1  write-protect flag of the active drive
- fdc_img_size  out  32  image size of the active drive
- fdc_ready  out  1  active drive has an image mounted
- hps_img_mounted  in  NDRIVES  per-drive mount pulse from the host
- hps_img_wp  in  1  write-protect flag, valid with a mount pulse
- hps_img_size  in  32  image size, valid with a mount pulse
- hps_sd_lba  out  32*NDRIVES  per-drive block address; drive i occupies bits [32i+31:32i]
- hps_sd_rd  out  NDRIVES  per-drive read request
- hps_sd_wr  out  NDRIVES  per-drive write request
- hps_sd_ack  in  NDRIVES  per-drive acknowledge
- hps_sd_buff_addr  in  9  shared buffer byte address
- hps_sd_buff_dout  in  8  shared read data byte
- hps_sd_buff_wr  in  1  shared read data strobe
- hps_sd_din  out  8*NDRIVES  per-drive write data byte

## Operation
- **Per-drive table.** Each drive has registers mounted, wp and size. On the rising edge of hps_img_mounted[i]:
  - size[i] is loaded from hps_img_size.
  - wp[i] is loaded from hps_img_wp.
  - mounted[i] is set to 1 if the new size is non-zero, and to 0 otherwise.
- **Active drive (act).**
  - act is loaded from dsel only in state IDLE; it holds its value in every other state.
  - A dsel value of NDRIVES or above is masked to its low log2(NDRIVES) bits.
- **Transfer drive (xdrv).** xdrv is latched from act on entry to REQ.
- **State machine.** States are IDLE, REQ, XFER, FAKE and ANNOUNCE.
  - IDLE → REQ when fdc_sd_rd or fdc_sd_wr is high and mounted[act] is 1. On this transition hps_sd_lba[xdrv] latches fdc_sd_lba, and the rd/wr type is latched.
  - IDLE → FAKE when fdc_sd_rd or fdc_sd_wr is high and mounted[act] is 0.
  - REQ: hps_sd_rd[xdrv] or hps_sd_wr[xdrv] is asserted according to the latched type. REQ → XFER on hps_sd_ack[xdrv] = 1.
  - XFER:
    - The rd/wr request is dropped.
    - fdc_sd_ack follows hps_sd_ack[xdrv].
    - fdc_sd_buff_addr and fdc_sd_dout are passed through from the host.
    - fdc_sd_dout_strobe = hps_sd_buff_wr AND hps_sd_ack[xdrv].
    - hps_sd_din[xdrv] = fdc_sd_din.
    - XFER → IDLE when hps_sd_ack[xdrv] = 0.
  - FAKE: fdc_sd_ack is driven high for exactly 2 cycles with no data strobes, then the state returns to IDLE. No hps request is issued.
  - ANNOUNCE: fdc_img_mounted is high for exactly 1 cycle, then the state returns to IDLE.
- **Announce trigger.** A pending-announce flag is set when either of the following occurs:
  - act changes value;
  - a mount pulse arrives for the drive equal to act (or equal to xdrv while a transfer is in flight).
- **Announce priority.** In IDLE, a pending announce takes priority over a new request. Entering ANNOUNCE clears the flag.
- **Status outputs.** fdc_img_wp = wp[act], fdc_img_size = size[act], fdc_ready = mounted[act]. These are combinational from registers.
- **Idle values.** Outside XFER, all hps_sd_din lanes are 0; likewise fdc_sd_dout_strobe is 0 and fdc_sd_buff_addr is 0.
- **Inactive lanes.** hps_sd_din lanes other than xdrv are always 0.

## Timing
- **Reset values.** All outputs are 0. act = 0, xdrv = 0, the table is cleared (mounted = 0, wp = 0, size = 0), the state is IDLE and pending-announce = 0.
- **Reset mid-transfer.** Reset takes effect asynchronously: hps_sd_rd/wr drop immediately.
- **Request latency.** An FDC request sampled in IDLE produces hps_sd_rd/wr high on the next cycle (registered).
- **Host ack to FDC ack.** 0 cycles in XFER (pass-through). fdc_sd_ack falls on the cycle hps_sd_ack falls.
- **Announce latency.** fdc_img_mounted fires 2 cycles after an act change, or later if a transfer is in flight at the time.
- **dsel changes during REQ or XFER.** These are ignored until IDLE. The transfer always completes on xdrv.
- **Mount pulse on a non-active drive during a transfer.** The table is updated and no announce occurs.
- **Mount pulse on xdrv during a transfer.** The table is updated, the transfer runs to completion, and the announce is made in the first IDLE cycle afterwards.
- **Simultaneous mount pulses.** Mount pulses on several drives in the same cycle are all applied.
- **Request held after FAKE.** A request still high after FAKE re-enters FAKE; no hang can occur.

## Test plan
- **Reset defaults.** Reset, then release with dsel = 0 → fdc_ready = 0 and all hps_sd_rd/wr = 0. A request while unmounted → fdc_sd_ack high for exactly 2 cycles and hps_sd_rd stays 0.
- **Mount and read on drive 1.** Mount drive 1 with size 0x5A000 and wp = 1, set dsel = 1 → one fdc_img_mounted pulse, fdc_img_size = 0x5A000, fdc_img_wp = 1. Then fdc_sd_rd with lba 7 → hps_sd_rd[1] = 1 one cycle later and hps_sd_lba[1] = 7. Host ack plus 512 strobes → 512 fdc_sd_dout_strobe pulses with matching bytes.
- **Write on drive 3.** fdc_sd_wr on drive 3 → hps_sd_wr[3] asserted. fdc_sd_din = 0xA5 appears only on hps_sd_din[3]; the other lanes stay 0.
- **dsel change mid-transfer.** Change dsel from 1 to 2 during XFER on drive 1 → the transfer completes on drive 1. act becomes 2 only after the ack falls, followed by one announce pulse.
- **Remount during transfer.** Remount the active drive with size 0 during a transfer → the transfer completes, then the announce fires and fdc_ready = 0.
- **Reset mid-transfer.** Assert nRESET during REQ → hps_sd_rd drops in the same cycle and the state returns to IDLE with the table cleared.
